instr_fetch_unit: RTL

Multi-cycle fetch sequencer that sits on the other side of the 16-bit program-counter register. It reads the current PC, issues a read request to instruction memory, and latches the returned word into an instruction register. It then hands the word to the decode/control FSM over a valid/ready handshake and writes the next PC back to the PC register: either PC+1 or a branch/jump redirect target.

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/fetch_ir_reg.sv | 27 ++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU constants for the fetch sequencer: FSM state encoding and
// the default first-fetch address.
package instr_fetch_unit_pkg;

    // Fetch FSM encoding, kept as plain 2-bit constants for older tools
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_ir_reg.sv
// Instruction register: holds the fetched word together with the address
// it came from. Load-enabled, asynchronously cleared.
module fetch_ir_reg #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    output logic [DW-1:0] ir_out,
    output logic [AW-1:0] ir_pc
);

    // Capture word and its address together on load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_out <= '0;
            ir_pc  <= '0;
        end else if (load) begin
            ir_out <= d_instr;
            ir_pc  <= d_pc;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads the PC register, requests the instruction word,
// holds it for the decoder over valid/ready and writes back PC+1 or a
// redirect target. mem_req/mem_addr are decoded; everything else is
// registered.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_in,
    output logic          pc_load,
    output logic [AW-1:0] pc_next,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          ir_valid,
    output logic [DW-1:0] ir_out,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready
);

    logic [1:0]    state, state_nxt;
    logic          pc_load_nxt;
    logic [AW-1:0] pc_next_nxt;
    logic          ir_load;

    // Memory request is live for every REQ cycle; the address follows the
    // PC register directly so no extra cycle is spent latching it.
    assign mem_req  = (state == ST_REQ);
    assign mem_addr = pc_in;

    // Next-state / next-PC decode; redirect outranks ack and ready
    always_comb begin
        state_nxt   = state;
        pc_load_nxt = 1'b0;
        pc_next_nxt = pc_next;
        ir_load     = 1'b0;
        if (state == ST_IDLE) begin
            state_nxt   = ST_FLUSH;
            pc_load_nxt = 1'b1;
            pc_next_nxt = RESET_PC;
        end else if (redirect) begin
            // Any ack this cycle is dropped; the word is not captured
            state_nxt   = ST_FLUSH;
            pc_load_nxt = 1'b1;
            pc_next_nxt = redirect_pc;
        end else begin
            case (state)
                ST_FLUSH: state_nxt = ST_REQ;
                ST_REQ: begin
                    if (mem_ack) begin
                        state_nxt   = ST_HOLD;
                        pc_load_nxt = 1'b1;
                        pc_next_nxt = pc_in + AW'(1);
                        ir_load     = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ir_ready) state_nxt = ST_REQ;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and registered PC-write / valid outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            pc_load  <= 1'b0;
            pc_next  <= RESET_PC;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_load  <= pc_load_nxt;
            pc_next  <= pc_next_nxt;
            ir_valid <= (state_nxt == ST_HOLD);
        end
    end

    fetch_ir_reg #(
        .AW(AW),
        .DW(DW)
    ) u_ir (
        .clk     (clk),
        .rst     (rst),
        .load    (ir_load),
        .d_instr (mem_rdata),
        .d_pc    (pc_in),
        .ir_out  (ir_out),
        .ir_pc   (ir_pc)
    );

endmodule
